except_ctrl: RTL and testbench
==============================

Name: except_ctrl

Overview:
- Sequences precise exception and ERET handling for the 5-stage MIPS core.
- Consumes the 32-bit excepttype word produced by the M-stage exception encoder.
- Drains outstanding memory traffic, issues a single CP0 update (EPC/Cause.BD/ExcCode/BadVAddr/EXL), flushes the pipeline, and redirects fetch to the exception vector or to EPC.

Parameters:
- EXC_VECTOR, 32'hBFC00380, fetch target for all exceptions and interrupts.
- DRAIN_TIMEOUT, 16, maximum DRAIN cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- excepttype_i  in  32  from exception encoder; 0 means none; 1/4/5/8/9/a/c/e per encoder codes
- except_pc_i  in  32  PC of the excepting M-stage instruction
- in_delayslot_i  in  1  excepting instruction is in a branch delay slot
- bad_vaddr_i  in  32  faulting address for AdEL/AdES
- cp0_epc_i  in  32  current CP0 EPC
- mem_busy_i  in  1  data-side request outstanding
- ifetch_busy_i  in  1  instruction-side request outstanding
- stall_o  out  1  freeze all stages
- flush_o  out  1  kill F/D/E/M stage contents
- exc_commit_o  out  1  one-cycle CP0 exception write strobe
- exc_code_o  out  5  Cause.ExcCode
- epc_o  out  32  value for EPC
- bd_o  out  1  value for Cause.BD
- badvaddr_we_o  out  1  BadVAddr write strobe
- badvaddr_o  out  32  value for BadVAddr
- eret_commit_o  out  1  one-cycle strobe to clear Status.EXL
- redirect_valid_o  out  1  one-cycle PC redirect strobe
- redirect_pc_o  out  32  redirect target
- drain_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset: state IDLE; all outputs and latched registers are 0.
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE:
  - If excepttype_i != 0, latch the code, PC, delay-slot flag, bad_vaddr_i and cp0_epc_i.
  - stall_o is asserted combinationally in the same cycle.
  - Next state is DRAIN if (mem_busy_i | ifetch_busy_i), otherwise COMMIT.
- DRAIN: stall_o=1. Go to COMMIT in the first cycle both busy inputs are 0.
- COMMIT: stall_o=1, flush_o=1.
  - Exception path: exc_commit_o=1.
  - ERET path (code e): eret_commit_o=1 and exc_commit_o=0.
- REDIRECT: flush_o=1, redirect_valid_o=1.
  - redirect_pc_o = latched EPC for ERET, otherwise EXC_VECTOR.
  - Next state IDLE.
- Minimum latency: detection at T, COMMIT at T+1, REDIRECT at T+2, IDLE at T+3.
- ExcCode mapping: 1->0, 4->4, 5->5, 8->8, 9->9, a->10, c->12. Any other nonzero code maps to 10.
- epc_o = in_delayslot ? pc-4 : pc, using modulo-2^32 arithmetic (pc=0 in a delay slot gives FFFFFFFC). bd_o = latched delay-slot flag.
- badvaddr_we_o is pulsed in COMMIT only for codes 4 and 5.
- excepttype_i is ignored outside IDLE; the first exception wins.
- rst asserted in any state returns the block to IDLE with no strobes in the following cycle.
- Strobe values (exc_code_o, epc_o, bd_o, badvaddr_o) are held stable from COMMIT until the next detection.

Optional Feature:
- EXC_DRAIN_TIMEOUT_EN defined:
  - A counter runs in DRAIN.
  - After DRAIN_TIMEOUT cycles with busy still high, force COMMIT and set drain_timeout_o.
  - drain_timeout_o stays set until rst.
- Not defined: DRAIN waits indefinitely; drain_timeout_o is tied 0 and no counter is present.

Decomposition:
- Package exc_pkg:
  - excepttype constants (EXC_INT=1, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=a, EXC_OV=c, EXC_ERET=e)
  - ExcCode constants
  - FSM state encoding
  - default EXC_VECTOR
- Sub-module exc_code_map: combinational excepttype->ExcCode, badvaddr-valid and is-eret decode.

Test Plan:
- Syscall: excepttype=8, pc=0x80001000, not in delay slot, not busy -> exc_commit at T+1 with code 8, EPC 0x80001000, bd=0; redirect at T+2 to 0xBFC00380.
- AdEL in delay slot: excepttype=4, pc=0x80002004, bad_vaddr=0x00000003 -> EPC 0x80002000, bd=1, badvaddr_we=1, badvaddr 0x00000003.
- Drain: excepttype=c with mem_busy_i high for 3 cycles -> stall held, commit one cycle after busy drops, code 12; flush asserted only in COMMIT and REDIRECT.
- ERET: excepttype=e, cp0_epc=0x80003010 -> eret_commit=1, exc_commit=0, redirect to 0x80003010.
- Overlap and reset: second excepttype=9 during DRAIN is ignored; rst during COMMIT gives IDLE with all strobes 0 the next cycle.
- With EXC_DRAIN_TIMEOUT_EN and DRAIN_TIMEOUT=16: busy stuck high -> COMMIT forced after 16 cycles, drain_timeout_o=1 until rst.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared constants for the exception controller: encoder excepttype codes,
// CP0 Cause.ExcCode values, FSM state encoding and the default vector.
package exc_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_COMMIT   = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

endpackage

// File: rtl/exc_code_map.sv
// Combinational decode of the encoder excepttype word into Cause.ExcCode,
// a BadVAddr-valid flag (address errors) and an ERET flag.
module exc_code_map
    import exc_pkg::*;
(
    input  logic [31:0] excepttype,
    output logic [4:0]  exc_code,
    output logic        badvaddr_valid,
    output logic        is_eret
);

    // Unknown nonzero codes are reported as reserved instruction.
    always_comb begin
        exc_code = EXCCODE_RI;
        case (excepttype)
            EXC_INT:  exc_code = EXCCODE_INT;
            EXC_ADEL: exc_code = EXCCODE_ADEL;
            EXC_ADES: exc_code = EXCCODE_ADES;
            EXC_SYS:  exc_code = EXCCODE_SYS;
            EXC_BP:   exc_code = EXCCODE_BP;
            EXC_RI:   exc_code = EXCCODE_RI;
            EXC_OV:   exc_code = EXCCODE_OV;
            default:  exc_code = EXCCODE_RI;
        endcase
    end

    assign badvaddr_valid = (excepttype == EXC_ADEL) || (excepttype == EXC_ADES);
    assign is_eret        = (excepttype == EXC_ERET);

endmodule

// File: rtl/except_ctrl.sv
// Precise exception / ERET sequencer: IDLE -> [DRAIN] -> COMMIT -> REDIRECT.
// Optional drain watchdog enabled with `define EXC_DRAIN_TIMEOUT_EN.
module except_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEFAULT,
    parameter int          DRAIN_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] except_pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_vaddr_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        mem_busy_i,
    input  logic        ifetch_busy_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        exc_commit_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] epc_o,
    output logic        bd_o,
    output logic        badvaddr_we_o,
    output logic [31:0] badvaddr_o,
    output logic        eret_commit_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        drain_timeout_o
);

    if (DRAIN_TIMEOUT < 1) begin : g_bad_timeout
        $error("DRAIN_TIMEOUT must be at least 1");
    end

    logic [1:0]  state, state_nx;
    logic        busy, detect, drain_exit;
    logic [4:0]  map_code;
    logic        map_bva_valid, map_eret;
    logic [4:0]  code_q;
    logic [31:0] epc_q, bva_q, cp0_epc_q;
    logic        bd_q, bva_valid_q, eret_q;

    assign busy   = mem_busy_i | ifetch_busy_i;
    assign detect = (state == ST_IDLE) && (excepttype_i != 32'h0);

    exc_code_map u_code_map (
        .excepttype     (excepttype_i),
        .exc_code       (map_code),
        .badvaddr_valid (map_bva_valid),
        .is_eret        (map_eret)
    );

`ifdef EXC_DRAIN_TIMEOUT_EN
    localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
    logic [CW-1:0] drain_cnt;
    logic          timeout_q, timeout_hit;

    // Fires on the last allowed DRAIN cycle while traffic is still pending.
    assign timeout_hit = (state == ST_DRAIN) && busy && (drain_cnt == CW'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end

    assign drain_exit      = !busy || timeout_hit;
    assign drain_timeout_o = timeout_q;
`else
    assign drain_exit      = !busy;
    assign drain_timeout_o = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (detect) state_nx = busy ? ST_DRAIN : ST_COMMIT;
            ST_DRAIN:    if (drain_exit) state_nx = ST_COMMIT;
            ST_COMMIT:   state_nx = ST_REDIRECT;
            ST_REDIRECT: state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Only the first exception seen in IDLE is captured; later codes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q      <= '0;
            epc_q       <= '0;
            bd_q        <= 1'b0;
            bva_q       <= '0;
            bva_valid_q <= 1'b0;
            eret_q      <= 1'b0;
            cp0_epc_q   <= '0;
        end else if (detect) begin
            code_q      <= map_code;
            epc_q       <= in_delayslot_i ? except_pc_i - 32'd4 : except_pc_i;
            bd_q        <= in_delayslot_i;
            bva_q       <= bad_vaddr_i;
            bva_valid_q <= map_bva_valid;
            eret_q      <= map_eret;
            cp0_epc_q   <= cp0_epc_i;
        end
    end

    assign stall_o       = detect || (state == ST_DRAIN) || (state == ST_COMMIT);
    assign flush_o       = (state == ST_COMMIT) || (state == ST_REDIRECT);
    assign exc_commit_o  = (state == ST_COMMIT) && !eret_q;
    assign eret_commit_o = (state == ST_COMMIT) && eret_q;
    assign badvaddr_we_o = (state == ST_COMMIT) && bva_valid_q;

    // redirect_valid_o carries no ready: fetch must take the target in the
    // single cycle it is high, and redirect_pc_o is 0 whenever it is low.
    assign redirect_valid_o = (state == ST_REDIRECT);
    assign redirect_pc_o    = (state != ST_REDIRECT) ? 32'h0 :
                              eret_q ? cp0_epc_q : EXC_VECTOR;

    assign exc_code_o = code_q;
    assign epc_o      = epc_q;
    assign bd_o       = bd_q;
    assign badvaddr_o = bva_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: transaction-level expected-output
// timeline per exception, compared every cycle, plus literal spot checks.
module tb_except_ctrl;

    localparam int W = 109;
    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam int TO_CYC = 16;
`ifdef EXC_DRAIN_TIMEOUT_EN
    localparam int TO_EN = 1;
`else
    localparam int TO_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] excepttype_i, except_pc_i, bad_vaddr_i, cp0_epc_i;
    logic        in_delayslot_i, mem_busy_i, ifetch_busy_i;
    logic        stall_o, flush_o, exc_commit_o, bd_o, badvaddr_we_o;
    logic        eret_commit_o, redirect_valid_o, drain_timeout_o;
    logic [4:0]  exc_code_o;
    logic [31:0] epc_o, badvaddr_o, redirect_pc_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] act;

    // model of the held CP0 values and sticky flag
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_bva;
    logic        m_bd, m_dto;

    // observations recorded by the compare process for literal checks
    int          det_cyc, last_commit_cyc, last_redir_cyc;
    logic [31:0] last_rpc;
    logic        last_exc, last_eret, last_bwe;

    except_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .excepttype_i     (excepttype_i),
        .except_pc_i      (except_pc_i),
        .in_delayslot_i   (in_delayslot_i),
        .bad_vaddr_i      (bad_vaddr_i),
        .cp0_epc_i        (cp0_epc_i),
        .mem_busy_i       (mem_busy_i),
        .ifetch_busy_i    (ifetch_busy_i),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .exc_commit_o     (exc_commit_o),
        .exc_code_o       (exc_code_o),
        .epc_o            (epc_o),
        .bd_o             (bd_o),
        .badvaddr_we_o    (badvaddr_we_o),
        .badvaddr_o       (badvaddr_o),
        .eret_commit_o    (eret_commit_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .drain_timeout_o  (drain_timeout_o)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign act = {stall_o, flush_o, exc_commit_o, exc_code_o, epc_o, bd_o, badvaddr_we_o,
                  badvaddr_o, eret_commit_o, redirect_valid_o, redirect_pc_o, drain_timeout_o};

    function automatic logic [4:0] exp_code(input logic [31:0] t);
        if (t == 32'h1) return 5'd0;
        if (t == 32'h4) return 5'd4;
        if (t == 32'h5) return 5'd5;
        if (t == 32'h8) return 5'd8;
        if (t == 32'h9) return 5'd9;
        if (t == 32'ha) return 5'd10;
        if (t == 32'hc) return 5'd12;
        return 5'd10;
    endfunction

    function automatic logic [31:0] rand_code();
        case ($urandom_range(0, 8))
            0: return 32'h1;
            1: return 32'h4;
            2: return 32'h5;
            3: return 32'h8;
            4: return 32'h9;
            5: return 32'ha;
            6: return 32'hc;
            7: return 32'he;
            default: return $urandom | 32'h10;
        endcase
    endfunction

    task automatic push_exp(input logic stall, input logic flush, input logic excc,
                            input logic eretc, input logic bwe, input logic rv,
                            input logic [31:0] rpc);
        exp_q.push_back({stall, flush, excc, m_code, m_epc, m_bd, bwe, m_bva,
                         eretc, rv, rpc, m_dto});
    endtask

    task automatic clear_model();
        m_code = '0; m_epc = '0; m_bva = '0; m_bd = 1'b0; m_dto = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // scoreboard: one expected output vector per driven cycle
    task automatic compare_cycle();
        logic [W-1:0] e;
        if (exc_commit_o || eret_commit_o) begin
            last_commit_cyc = cyc;
            last_exc        = exc_commit_o;
            last_eret       = eret_commit_o;
            last_bwe        = badvaddr_we_o;
        end
        if (redirect_valid_o) begin
            last_redir_cyc = cyc;
            last_rpc       = redirect_pc_o;
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        n_checks++;
        if (act !== e) begin
            n_errors++;
            $display("FAIL cycle_outputs cyc=%0d got=%h expected=%h", cyc, act, e);
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            excepttype_i   = 32'h0;
            except_pc_i    = $urandom;
            in_delayslot_i = 1'($urandom_range(0, 1));
            bad_vaddr_i    = $urandom;
            cp0_epc_i      = $urandom;
            mem_busy_i     = 1'($urandom_range(0, 1));
            ifetch_busy_i  = 1'($urandom_range(0, 1));
            push_exp(0, 0, 0, 0, 0, 0, 32'h0);
        end
    endtask

    // One exception: busy held for nbusy cycles from detection; noise is the
    // excepttype presented on every later cycle of the sequence.
    task automatic run_txn(input logic [31:0] code, input logic [31:0] pc, input logic [31:0] bva,
                           input logic [31:0] epc_in, input logic ds, input int nbusy,
                           input logic [31:0] noise);
        int d;
        logic capped, eret, bwe_en;
        logic [1:0] b;
        capped = (TO_EN != 0) && (nbusy > TO_CYC);
        d      = capped ? TO_CYC : nbusy;
        eret   = (code == 32'he);
        bwe_en = (code == 32'h4) || (code == 32'h5);
        for (int i = 0; i < d + 3; i++) begin
            @(posedge clk); #1;
            excepttype_i   = (i == 0) ? code : noise;
            except_pc_i    = (i == 0) ? pc : $urandom;
            bad_vaddr_i    = (i == 0) ? bva : $urandom;
            cp0_epc_i      = (i == 0) ? epc_in : $urandom;
            in_delayslot_i = (i == 0) ? ds : 1'($urandom_range(0, 1));
            if (i < nbusy)   b = 2'($urandom_range(1, 3));
            else if (i <= d) b = 2'b00;
            else             b = 2'($urandom_range(0, 3));
            mem_busy_i    = b[0];
            ifetch_busy_i = b[1];
            if (i == 0) begin
                push_exp(1, 0, 0, 0, 0, 0, 32'h0);
                det_cyc = cyc;
                m_code  = exp_code(code);
                m_epc   = ds ? pc - 32'd4 : pc;
                m_bd    = ds;
                m_bva   = bva;
            end else if (i <= d) begin
                push_exp(1, 0, 0, 0, 0, 0, 32'h0);
            end else if (i == d + 1) begin
                if (capped) m_dto = 1'b1;
                push_exp(1, 1, !eret, eret, bwe_en, 0, 32'h0);
            end else begin
                push_exp(0, 1, 0, 0, 0, 1, eret ? epc_in : EXC_VEC);
            end
        end
    endtask

    task automatic reset_in_commit(input logic [31:0] code);
        @(posedge clk); #1;
        excepttype_i = code; except_pc_i = 32'h80007000; in_delayslot_i = 1'b0;
        bad_vaddr_i = 32'h5; cp0_epc_i = 32'h80001234; mem_busy_i = 1'b0; ifetch_busy_i = 1'b0;
        push_exp(1, 0, 0, 0, 0, 0, 32'h0);
        m_code = exp_code(code); m_epc = 32'h80007000; m_bd = 1'b0; m_bva = 32'h5;
        @(posedge clk); #1;
        rst = 1'b1; excepttype_i = 32'h0;
        push_exp(1, 1, code != 32'he, code == 32'he, code == 32'h5 || code == 32'h4, 0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        push_exp(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1; excepttype_i = 32'h0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
    endtask

    initial begin
        rst = 1'b1;
        excepttype_i = '0; except_pc_i = '0; in_delayslot_i = 1'b0; bad_vaddr_i = '0;
        cp0_epc_i = '0; mem_busy_i = 1'b0; ifetch_busy_i = 1'b0;
        det_cyc = 0; last_commit_cyc = -1; last_redir_cyc = -1;
        last_rpc = '0; last_exc = 1'b0; last_eret = 1'b0; last_bwe = 1'b0;
        clear_model();
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        check("reset_exc_code", 32'(exc_code_o), 32'h0);
        check("reset_epc", epc_o, 32'h0);
        check("reset_redirect_pc", redirect_pc_o, 32'h0);
        check("reset_timeout", 32'(drain_timeout_o), 32'h0);

        // syscall, no drain
        run_txn(32'h8, 32'h80001000, 32'h0, 32'h0, 1'b0, 0, 32'h0);
        idle(1);
        check("sys_commit_latency", 32'(last_commit_cyc - det_cyc), 32'd1);
        check("sys_redirect_latency", 32'(last_redir_cyc - det_cyc), 32'd2);
        check("sys_redirect_pc", last_rpc, 32'hBFC00380);
        check("sys_code", 32'(exc_code_o), 32'd8);
        check("sys_epc", epc_o, 32'h80001000);
        check("sys_bd", 32'(bd_o), 32'h0);
        check("sys_exc_commit", 32'(last_exc), 32'h1);

        // AdEL in a delay slot
        run_txn(32'h4, 32'h80002004, 32'h00000003, 32'h0, 1'b1, 0, 32'h0);
        idle(1);
        check("adel_epc", epc_o, 32'h80002000);
        check("adel_bd", 32'(bd_o), 32'h1);
        check("adel_badvaddr", badvaddr_o, 32'h00000003);
        check("adel_badvaddr_we", 32'(last_bwe), 32'h1);

        // overflow with three busy cycles
        run_txn(32'hc, 32'h80004000, 32'h0, 32'h0, 1'b0, 3, 32'h0);
        idle(1);
        check("drain_commit_latency", 32'(last_commit_cyc - det_cyc), 32'd4);
        check("drain_code", 32'(exc_code_o), 32'd12);

        // ERET
        run_txn(32'he, 32'h80005000, 32'h0, 32'h80003010, 1'b0, 0, 32'h0);
        idle(1);
        check("eret_commit", 32'(last_eret), 32'h1);
        check("eret_no_exc_commit", 32'(last_exc), 32'h0);
        check("eret_redirect_pc", last_rpc, 32'h80003010);

        // second exception during DRAIN is ignored
        run_txn(32'hc, 32'h80006000, 32'h0, 32'h0, 1'b0, 2, 32'h9);
        idle(1);
        check("overlap_code", 32'(exc_code_o), 32'd12);

        // pc 0 in a delay slot wraps
        run_txn(32'h1, 32'h0, 32'h0, 32'h0, 1'b1, 0, 32'h0);
        idle(1);
        check("wrap_epc", epc_o, 32'hFFFFFFFC);
        check("int_code", 32'(exc_code_o), 32'd0);

        // reset while in COMMIT
        reset_in_commit(32'h5);
        check("rst_exc_commit", 32'(exc_commit_o), 32'h0);
        check("rst_badvaddr_we", 32'(badvaddr_we_o), 32'h0);
        check("rst_epc", epc_o, 32'h0);
        idle(1);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            run_txn(rand_code(), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 5), ($urandom_range(0, 1) != 0) ? rand_code() : 32'h0);
            idle($urandom_range(0, 2));
        end

`ifdef EXC_DRAIN_TIMEOUT_EN
        run_txn(32'h8, 32'h80008000, 32'h0, 32'h0, 1'b0, 20, 32'h0);
        idle(2);
        check("timeout_commit_latency", 32'(last_commit_cyc - det_cyc), 32'd17);
        check("timeout_flag", 32'(drain_timeout_o), 32'h1);
        do_reset(1);
        idle(1);
        check("timeout_flag_cleared", 32'(drain_timeout_o), 32'h0);
`else
        do_reset(1);
        idle(1);
        check("timeout_tied_low", 32'(drain_timeout_o), 32'h0);
`endif

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
